sram_readback: RTL and testbench

- Read-side engine for the capture SRAM.
- After a capture completes, walks the sample memory backwards from the last-written word for a programmed number of words. It issues one-cycle-latency reads and presents the words as a valid/ready stream (with byte-lane keep and a last flag) to the downstream serializer/transmitter.
- Absorbs downstream backpressure without losing in-flight read data, using a 2-entry skid FIFO.

---
 rtl/sram_readback.sv | 188 ++++++++++++++++++
 tb/tb_sram_readback.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_readback.sv
// sram_readback
// Read-side engine for the capture SRAM. After a capture, it walks the
// sample memory backwards from the last written word for a programmed
// number of words. Reads have one cycle of latency. The words leave as a
// valid/ready stream with a byte-lane keep and a last flag. A 2-entry skid
// FIFO absorbs downstream backpressure so no in-flight read data is lost.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse that begins a readback
//   start_addr        address of the last written word (read first)
//   read_count        number of words to read, 0..MSZ
//   lane_mask         byte lanes to report on out_tkeep
//   abort             synchronous cancel of an active readback
//   mem_rd_en/addr    memory read strobe and address
//   mem_rd_data       read data, valid one cycle after mem_rd_en
//   out_t*            downstream stream (valid/ready/last/keep/data)
//   busy              readback in progress
//   done              one-cycle pulse after the last word is transferred
module sram_readback #(
   parameter int MSZ = 6144,
   parameter int MAW = 13,
   parameter int MDW = 32,
   parameter int MKW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [MAW-1:0] start_addr,
   input  logic [MAW:0]   read_count,
   input  logic [MKW-1:0] lane_mask,
   input  logic           abort,
   output logic           mem_rd_en,
   output logic [MAW-1:0] mem_rd_addr,
   input  logic [MDW-1:0] mem_rd_data,
   output logic           out_tvalid,
   input  logic           out_tready,
   output logic           out_tlast,
   output logic [MKW-1:0] out_tkeep,
   output logic [MDW-1:0] out_tdata,
   output logic           busy,
   output logic           done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [MAW-1:0] ADDR_TOP = MAW'(MSZ - 1);
   localparam logic [MAW-1:0] ADDR_ONE = MAW'(1);
   localparam logic [MAW:0]   CNT_ONE  = (MAW+1)'(1);

   logic [1:0]     state;
   logic [MAW-1:0] addr;
   logic [MAW:0]   remaining;
   logic [MKW-1:0] keep;
   logic           inflight;
   logic           inflight_last;

   logic [MDW-1:0] fifo_data [2];
   logic           fifo_last [2];
   logic           rd_ptr;
   logic           wr_ptr;
   logic [1:0]     fifo_count;

   logic           pop;
   logic           push;
   logic           flush;
   logic           issue;
   logic [2:0]     credit;

   // Stream side is a direct view of the FIFO head. Data, last and keep are
   // forced to zero while nothing is valid so idle outputs look like reset.
   assign out_tvalid  = (fifo_count != 2'd0);
   assign out_tdata   = out_tvalid ? fifo_data[rd_ptr] : '0;
   assign out_tlast   = out_tvalid ? fifo_last[rd_ptr] : 1'b0;
   assign out_tkeep   = out_tvalid ? keep : '0;
   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr;

   // Issue decision. Credit is the number of FIFO slots already claimed by
   // stored words plus the word on the memory bus. A word leaving the head
   // this cycle frees its slot in time for the new read to land, which is
   // what allows one word per cycle with only two entries. The abort cycle
   // issues nothing, so the flush cannot race a new read.
   always_comb begin
      pop    = out_tvalid & out_tready;
      push   = inflight;
      flush  = abort && (state != IDLE);
      credit = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
      issue  = (state == READ) && (remaining != '0) && !abort && (credit < 3'd2);
   end

   // Control FSM: latches the request, walks the address downward with wrap
   // at zero, and waits in DRAIN for the last-tagged word to be accepted.
   // A zero-length request only produces a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         keep          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         done          <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remaining == CNT_ONE);
         case (state)
            IDLE: begin
               if (start) begin
                  if (read_count != '0) begin
                     addr      <= start_addr;
                     remaining <= read_count;
                     keep      <= lane_mask;
                     busy      <= 1'b1;
                     state     <= READ;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            READ: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (issue) begin
                  addr      <= (addr == '0) ? ADDR_TOP : addr - ADDR_ONE;
                  remaining <= remaining - CNT_ONE;
                  if (remaining == CNT_ONE) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (pop && out_tlast) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Two-entry skid FIFO. Read data is captured the cycle after the issue,
   // together with its last tag. Push and pop may happen in the same cycle.
   // An abort discards everything stored, and the flush also drops a word
   // that is still on the memory bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
      end else if (flush) begin
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= mem_rd_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_readback.sv
// tb_sram_readback
// Scoreboard bench for sram_readback. The stimulus process queues the
// hand-computed words of each directed readback. A negedge monitor pops and
// compares every accepted word, checks that stalled words hold steady, and
// checks that no read is issued beyond the two-slot credit. The memory
// model returns mem[a] = a one cycle after each read strobe.
module tb_sram_readback;

   localparam int MSZ = 6144;
   localparam int MAW = 13;
   localparam int MDW = 32;
   localparam int MKW = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [MAW-1:0] start_addr = '0;
   logic [MAW:0]   read_count = '0;
   logic [MKW-1:0] lane_mask = '0;
   logic           abort = 1'b0;
   logic           out_tready = 1'b0;
   logic [MDW-1:0] mem_rd_data = '0;
   logic           mem_rd_en;
   logic [MAW-1:0] mem_rd_addr;
   logic           out_tvalid;
   logic           out_tlast;
   logic [MKW-1:0] out_tkeep;
   logic [MDW-1:0] out_tdata;
   logic           busy;
   logic           done;

   typedef struct {
      logic [MDW-1:0] data;
      logic           last;
      logic [MKW-1:0] keep;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   xfer_count = 0;
   int   done_count = 0;
   int   outstanding = 0;
   int   xfer_cyc[int];
   logic           prev_stall = 1'b0;
   logic [MDW-1:0] prev_data = '0;
   logic           prev_last = 1'b0;

   sram_readback #(.MSZ(MSZ), .MAW(MAW), .MDW(MDW), .MKW(MKW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .start_addr  (start_addr),
      .read_count  (read_count),
      .lane_mask   (lane_mask),
      .abort       (abort),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready),
      .out_tlast   (out_tlast),
      .out_tkeep   (out_tkeep),
      .out_tdata   (out_tdata),
      .busy        (busy),
      .done        (done)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Synchronous memory preloaded with mem[a] = a.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= MDW'(mem_rd_addr);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic queueWord(input logic [MDW-1:0] d, input logic l, input logic [MKW-1:0] k);
      exp_t e;
      e.data = d;
      e.last = l;
      e.keep = k;
      exp_q.push_back(e);
   endtask

   // One-cycle start pulse with the request fields.
   task automatic applyStimulus(input logic [MAW-1:0] a, input logic [MAW:0] n, input logic [MKW-1:0] m);
      @(posedge clk); #1;
      start_addr = a;
      read_count = n;
      lane_mask  = m;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // Waits for done_count to reach target, optionally toggling out_tready
   // with the backpressure pattern 1,0,0,1,0,1.
   task automatic waitDone(input string name, input int target, input int budget, input bit pattern);
      bit pat [6];
      int n;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n = 0;
      while (done_count < target && n < budget) begin
         if (pattern) out_tready = pat[n % 6];
         @(posedge clk); #1;
         n++;
      end
      out_tready = 1'b1;
      checkOutput({name, "_done_seen"}, (done_count >= target), 1);
   endtask

   task automatic runBasic(input string tag);
      int bd;
      int bx;
      int gap;
      bd = done_count;
      bx = xfer_count;
      out_tready = 1'b1;
      queueWord(32'd10, 1'b0, 4'hF);
      queueWord(32'd9,  1'b0, 4'hF);
      queueWord(32'd8,  1'b0, 4'hF);
      queueWord(32'd7,  1'b1, 4'hF);
      applyStimulus(13'd10, 14'd4, 4'hF);
      waitDone(tag, bd + 1, 50, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      gap = (xfer_cyc.exists(bx) && xfer_cyc.exists(bx + 3)) ? xfer_cyc[bx + 3] - xfer_cyc[bx] : -1;
      checkOutput({tag, "_done_once"}, done_count - bd, 1);
      checkOutput({tag, "_busy_after"}, busy, 0);
      checkOutput({tag, "_word_count"}, xfer_count - bx, 4);
      checkOutput({tag, "_back_to_back"}, gap, 3);
      checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   // Monitor: samples at negedge, away from the active edge.
   initial begin
      bit   hs;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
         end else begin
            hs = out_tvalid && out_tready;
            if (prev_stall) begin
               checkOutput("hold_valid", out_tvalid, 1);
               checkOutput("hold_data", out_tdata, prev_data);
               checkOutput("hold_last", out_tlast, prev_last);
            end
            // Issued-but-not-accepted words, less the one leaving now,
            // must leave room in the two-entry FIFO.
            if (mem_rd_en) begin
               checkOutput("read_credit", ((outstanding - int'(hs)) < 2), 1);
            end
            if (hs) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_word: got %0h expected no word", out_tdata);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("word_data", out_tdata, e.data);
                  checkOutput("word_last", out_tlast, e.last);
                  checkOutput("word_keep", out_tkeep, e.keep);
               end
               xfer_cyc[xfer_count] = cyc;
               xfer_count++;
            end
            if (done) done_count++;
            outstanding = outstanding + int'(mem_rd_en) - int'(hs);
            if (abort && busy) outstanding = 0;
            prev_stall = out_tvalid && !out_tready && !(abort && busy);
            prev_data  = out_tdata;
            prev_last  = out_tlast;
         end
      end
   end

   // Global time bound.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus.
   initial begin
      int bd;
      int bx;
      int n;
      bit any_rd;
      bit any_valid;
      bit any_busy;

      // Reset values.
      #1 rst = 1'b1;
      #2;
      checkOutput("rst_mem_rd_en", mem_rd_en, 0);
      checkOutput("rst_mem_rd_addr", mem_rd_addr, 0);
      checkOutput("rst_tvalid", out_tvalid, 0);
      checkOutput("rst_tlast", out_tlast, 0);
      checkOutput("rst_tkeep", out_tkeep, 0);
      checkOutput("rst_tdata", out_tdata, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic readback 10,9,8,7.
      runBasic("basic");

      // Wrap through address 0.
      bx = xfer_count;
      queueWord(32'd1,    1'b0, 4'hF);
      queueWord(32'd0,    1'b0, 4'hF);
      queueWord(32'd6143, 1'b0, 4'hF);
      queueWord(32'd6142, 1'b1, 4'hF);
      applyStimulus(13'd1, 14'd4, 4'hF);
      waitDone("wrap", done_count + 1, 50, 1'b0);
      checkOutput("wrap_word_count", xfer_count - bx, 4);
      checkOutput("wrap_queue_empty", exp_q.size(), 0);

      // Backpressure with tready toggling.
      bx = xfer_count;
      queueWord(32'd100, 1'b0, 4'hF);
      queueWord(32'd99,  1'b0, 4'hF);
      queueWord(32'd98,  1'b0, 4'hF);
      queueWord(32'd97,  1'b0, 4'hF);
      queueWord(32'd96,  1'b0, 4'hF);
      queueWord(32'd95,  1'b1, 4'hF);
      applyStimulus(13'd100, 14'd6, 4'hF);
      waitDone("bp", done_count + 1, 100, 1'b1);
      checkOutput("bp_word_count", xfer_count - bx, 6);
      checkOutput("bp_queue_empty", exp_q.size(), 0);

      // Zero-length request.
      bd = done_count;
      applyStimulus(13'd50, 14'd0, 4'hF);
      any_rd = 1'b0;
      any_valid = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         any_rd    = any_rd | mem_rd_en;
         any_valid = any_valid | out_tvalid;
         any_busy  = any_busy | busy;
         @(posedge clk); #1;
      end
      checkOutput("zero_no_reads", any_rd, 0);
      checkOutput("zero_no_valid", any_valid, 0);
      checkOutput("zero_no_busy", any_busy, 0);
      checkOutput("zero_done_once", done_count - bd, 1);

      // Abort after five transfers; a second start while busy is ignored.
      bd = done_count;
      bx = xfer_count;
      for (int i = 0; i < 50; i++) begin
         queueWord(MDW'(2000 - i), (i == 49), 4'hF);
      end
      applyStimulus(13'd2000, 14'd50, 4'hF);
      applyStimulus(13'd5, 14'd3, 4'h3);
      n = 0;
      while ((xfer_count - bx) < 5 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("abort_five_seen", xfer_count - bx, 5);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_tvalid_drop", out_tvalid, 0);
      checkOutput("abort_tlast", out_tlast, 0);
      checkOutput("abort_busy", busy, 0);
      exp_q.delete();
      any_valid = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         any_valid = any_valid | out_tvalid;
         any_busy  = any_busy | busy;
         @(posedge clk); #1;
      end
      checkOutput("abort_stays_idle", any_valid, 0);
      checkOutput("abort_busy_stays", any_busy, 0);
      checkOutput("abort_no_done", done_count - bd, 0);
      checkOutput("abort_xfer_total", xfer_count - bx, 6);

      // Asynchronous reset while the FIFO is full under backpressure.
      out_tready = 1'b0;
      applyStimulus(13'd300, 14'd20, 4'hF);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("pre_rst_tvalid", out_tvalid, 1);
      checkOutput("pre_rst_no_read", mem_rd_en, 0);
      checkOutput("pre_rst_head", out_tdata, 300);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_mem_rd_en", mem_rd_en, 0);
      checkOutput("mid_rst_mem_rd_addr", mem_rd_addr, 0);
      checkOutput("mid_rst_tvalid", out_tvalid, 0);
      checkOutput("mid_rst_tlast", out_tlast, 0);
      checkOutput("mid_rst_tkeep", out_tkeep, 0);
      checkOutput("mid_rst_tdata", out_tdata, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_tready = 1'b1;
      runBasic("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
